// File: rtl/wb_pkg.sv
// Shared write-back definitions.
//   DW, RW    : default data / register-index widths
//   ZERO_REG  : hard-wired zero register, never written
//   wb_req_t  : {rd, data} write request, used by both producers and the skid FIFO
package wb_pkg;

    localparam int DW = 32;
    localparam int RW = 5;

    localparam logic [RW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_mux2.sv
// Generic 2:1 mux cell.
//   sel : 0 selects a, 1 selects b
//   a,b : W-bit inputs
//   y   : W-bit output
module wb_mux2 #(
    parameter int W = 32
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/wb_skid_fifo.sv
// In-order skid FIFO for EXE results that lost the register-file port.
//   clk, reset         : clock, synchronous active-high reset
//   push, pushData     : enqueue at tail (caller guarantees !full)
//   pop                : dequeue head (caller guarantees !empty)
//   head               : current head entry (valid when !empty)
//   count, full, empty : occupancy status, all from registered state
// DEPTH need not be a power of two; pointers wrap explicitly.
module wb_skid_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = wb_req_t,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  T              pushData,
    input  logic          pop,
    output T              head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    T              mem [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head  = mem[rdPtr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= nextPtr(wrPtr);
            end
            if (pop)
                rdPtr <= nextPtr(rdPtr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter.
// Load returns cannot be back-pressured and always win the port; a colliding
// EXE result is parked in an in-order skid FIFO. Issue stalls only when the
// FIFO is full.
//   clk, reset                        : clock, synchronous active-high reset
//   exe_valid/exe_rd/exe_data         : EXE result, handshake with exe_ready
//   exe_ready, stall                  : accept / stall (stall = ~exe_ready)
//   mem_valid/mem_rd/mem_data         : load return, always consumed
//   wb_we/wb_rd/wb/Mem2Reg            : registered write-back outputs
//   fifo_count                        : skid FIFO occupancy
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter int  DW    = wb_pkg::DW,
    parameter int  RW    = wb_pkg::RW,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          exe_valid,
    input  logic [RW-1:0] exe_rd,
    input  logic [DW-1:0] exe_data,
    output logic          exe_ready,
    input  logic          mem_valid,
    input  logic [RW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    output logic          wb_we,
    output logic [RW-1:0] wb_rd,
    output logic [DW-1:0] wb,
    output logic          Mem2Reg,
    output logic          stall,
    output logic [CW-1:0] fifo_count
);

    // Same layout as wb_req_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } reqT;

    reqT     exeReq;
    reqT     fifoHead;
    logic    fifoFull;
    logic    fifoEmpty;
    logic    memHit;
    logic    exeAcc;
    logic    directWr;
    logic    fifoPush;
    logic    fifoPop;
    logic    weNext;
    logic [RW-1:0] rdNext;
    logic [DW-1:0] exeSideData;
    logic [DW-1:0] dataNext;

    assign exeReq = '{rd: exe_rd, data: exe_data};

    // Ready comes only from FIFO occupancy: no path from exe_*/mem_*.
    assign exe_ready = ~fifoFull;
    assign stall     = fifoFull;

    // Register 0 writes are filtered before arbitration.
    assign memHit   = mem_valid && (mem_rd != RW'(ZERO_REG));
    assign exeAcc   = exe_valid && exe_ready && (exe_rd != RW'(ZERO_REG));

    assign fifoPop  = !memHit && !fifoEmpty;
    assign directWr = !memHit && fifoEmpty && exeAcc;
    assign fifoPush = exeAcc && !directWr;

    assign weNext      = memHit || !fifoEmpty || exeAcc;
    assign rdNext      = memHit ? mem_rd : (!fifoEmpty ? fifoHead.rd : exe_rd);
    assign exeSideData = !fifoEmpty ? fifoHead.data : exe_data;

    wb_skid_fifo #(
        .DEPTH (DEPTH),
        .T     (reqT)
    ) uSkid (
        .clk      (clk),
        .reset    (reset),
        .push     (fifoPush),
        .pushData (exeReq),
        .pop      (fifoPop),
        .head     (fifoHead),
        .count    (fifo_count),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    // Select is the next-cycle Mem2Reg value.
    wb_mux2 #(
        .W (DW)
    ) uDataMux (
        .sel (memHit),
        .a   (exeSideData),
        .b   (mem_data),
        .y   (dataNext)
    );

    // wb/wb_rd/Mem2Reg hold on idle cycles; only wb_we drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_we   <= 1'b0;
            wb_rd   <= '0;
            wb      <= '0;
            Mem2Reg <= 1'b0;
        end else begin
            wb_we <= weNext;
            if (weNext) begin
                wb_rd   <= rdNext;
                wb      <= dataNext;
                Mem2Reg <= memHit;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DEPTH=2, DW=32, RW=5).
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          exe_valid;
    logic [RW-1:0] exe_rd;
    logic [DW-1:0] exe_data;
    logic          exe_ready;
    logic          mem_valid;
    logic [RW-1:0] mem_rd;
    logic [DW-1:0] mem_data;
    logic          wb_we;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb;
    logic          Mem2Reg;
    logic          stall;
    logic [CW-1:0] fifo_count;

    int nChk  = 0;
    int nPass = 0;

    wb_port_arbiter #(.DEPTH(DEPTH), .DW(DW), .RW(RW)) dut (
        .clk        (clk),
        .reset      (reset),
        .exe_valid  (exe_valid),
        .exe_rd     (exe_rd),
        .exe_data   (exe_data),
        .exe_ready  (exe_ready),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb         (wb),
        .Mem2Reg    (Mem2Reg),
        .stall      (stall),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChk++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ev, input logic [RW-1:0] er, input logic [DW-1:0] ed,
                         input logic mv, input logic [RW-1:0] mr, input logic [DW-1:0] md);
        exe_valid = ev; exe_rd = er; exe_data = ed;
        mem_valid = mv; mem_rd = mr; mem_data = md;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Checks one registered write-back beat.
    task automatic chkWr(input string tag, input logic [RW-1:0] rd, input logic [DW-1:0] d,
                         input logic m2r);
        chk({tag, ".we"},  64'(wb_we),   64'(1'b1));
        chk({tag, ".rd"},  64'(wb_rd),   64'(rd));
        chk({tag, ".wb"},  64'(wb),      64'(d));
        chk({tag, ".m2r"}, 64'(Mem2Reg), 64'(m2r));
    endtask

    initial begin
        // Reset with both producers active: reset must win.
        reset = 1'b1;
        drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd3, 32'h33);
        tick(); tick();
        chk("rst.we",    64'(wb_we),      64'(0));
        chk("rst.wb",    64'(wb),         64'(0));
        chk("rst.rd",    64'(wb_rd),      64'(0));
        chk("rst.m2r",   64'(Mem2Reg),    64'(0));
        chk("rst.cnt",   64'(fifo_count), 64'(0));
        chk("rst.rdy",   64'(exe_ready),  64'(1));
        chk("rst.stall", 64'(stall),      64'(0));
        reset = 1'b0;
        idle();
        tick();
        chk("idle.we", 64'(wb_we), 64'(0));

        // EXE only: direct write, FIFO bypassed.
        drive(1'b1, 5'd5, 32'h11, 1'b0, '0, '0);
        tick();
        chkWr("exe", 5'd5, 32'h11, 1'b0);
        chk("exe.cnt", 64'(fifo_count), 64'(0));

        // Collision: mem wins, EXE parked then drained.
        drive(1'b1, 5'd7, 32'hBB, 1'b1, 5'd3, 32'hAA);
        tick();
        chkWr("col1", 5'd3, 32'hAA, 1'b1);
        chk("col1.cnt", 64'(fifo_count), 64'(1));
        idle();
        tick();
        chkWr("col2", 5'd7, 32'hBB, 1'b0);
        chk("col2.cnt", 64'(fifo_count), 64'(0));

        // Fill and stall: three mem beats while EXE pushes rd 1,2 then holds rd 3.
        drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd10, 32'hA10);
        tick();
        chkWr("fill1", 5'd10, 32'hA10, 1'b1);
        chk("fill1.cnt", 64'(fifo_count), 64'(1));
        drive(1'b1, 5'd2, 32'h102, 1'b1, 5'd11, 32'hA11);
        tick();
        chkWr("fill2", 5'd11, 32'hA11, 1'b1);
        chk("fill2.cnt",   64'(fifo_count), 64'(2));
        chk("fill2.rdy",   64'(exe_ready),  64'(0));
        chk("fill2.stall", 64'(stall),      64'(1));
        drive(1'b1, 5'd3, 32'h103, 1'b1, 5'd12, 32'hA12);
        tick();
        chkWr("fill3", 5'd12, 32'hA12, 1'b1);
        chk("fill3.cnt",   64'(fifo_count), 64'(2));
        chk("fill3.stall", 64'(stall),      64'(1));
        drive(1'b1, 5'd3, 32'h103, 1'b0, '0, '0);
        tick();
        chkWr("drain1", 5'd1, 32'h101, 1'b0);
        chk("drain1.cnt", 64'(fifo_count), 64'(1));
        chk("drain1.rdy", 64'(exe_ready),  64'(1));
        tick();
        chkWr("drain2", 5'd2, 32'h102, 1'b0);
        chk("drain2.cnt", 64'(fifo_count), 64'(1));
        idle();
        tick();
        chkWr("drain3", 5'd3, 32'h103, 1'b0);
        chk("drain3.cnt", 64'(fifo_count), 64'(0));

        // Simultaneous push/pop.
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd13, 32'hA13);
        tick();
        chk("pp0.cnt", 64'(fifo_count), 64'(1));
        drive(1'b1, 5'd6, 32'h66, 1'b0, '0, '0);
        tick();
        chkWr("pp1", 5'd4, 32'h44, 1'b0);
        chk("pp1.cnt", 64'(fifo_count), 64'(1));
        idle();
        tick();
        chkWr("pp2", 5'd6, 32'h66, 1'b0);
        chk("pp2.cnt", 64'(fifo_count), 64'(0));

        // Register 0 filter.
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd0, 32'hDEAD);
        tick();
        chkWr("r0mem", 5'd9, 32'h99, 1'b0);
        chk("r0mem.cnt", 64'(fifo_count), 64'(0));
        drive(1'b1, 5'd0, 32'h77, 1'b0, '0, '0);
        tick();
        chk("r0exe.we",  64'(wb_we), 64'(0));
        chk("r0exe.rd",  64'(wb_rd), 64'(9));
        chk("r0exe.wb",  64'(wb),    64'(32'h99));
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'hBEEF);
        tick();
        chk("r0only.we", 64'(wb_we), 64'(0));
        chk("r0only.wb", 64'(wb),    64'(32'h99));

        // Idle hold after a memory write keeps Mem2Reg.
        drive(1'b0, '0, '0, 1'b1, 5'd14, 32'hC14);
        tick();
        chkWr("hold0", 5'd14, 32'hC14, 1'b1);
        idle();
        tick();
        chk("hold.we",  64'(wb_we),   64'(0));
        chk("hold.m2r", 64'(Mem2Reg), 64'(1));
        chk("hold.wb",  64'(wb),      64'(32'hC14));

        // Reset discards buffered entries.
        drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd15, 32'hC15);
        tick();
        chk("mid.cnt", 64'(fifo_count), 64'(1));
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        chk("mid.rstcnt", 64'(fifo_count), 64'(0));
        chk("mid.rstwe",  64'(wb_we),      64'(0));
        tick();
        chk("mid.nowr",   64'(wb_we),      64'(0));

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
